// File: rtl/iob_plic_claim_master_if.sv
// IOb request/response bundle between the claim master (initiator) and the
// PLIC target port (responder).
//
// Handshake: a request transfers on a rising clk edge where avalid and ready
// are both high; the initiator holds avalid, addr, wdata and wstrb stable
// until then. rvalid is a single-cycle read-data strobe with no back-pressure,
// and it arrives no earlier than the cycle after the read was accepted.
interface iob_plic_claim_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  avalid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output avalid, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  avalid, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/iob_plic_claim_master.sv
// PLIC claim/complete initiator for one target.
// On an interrupt it reads the claim register once, hands the ID to a hardware
// handler, waits for the handler to finish and writes the ID back to complete.
// Optional feature: define IOB_PLIC_CLAIM_MASTER_TIMEOUT_EN to abandon a claim
// read whose data never arrives (err_o pulses, FSM returns to IDLE).
module iob_plic_claim_master #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 32,
  parameter int                ID_W       = 8,
  parameter logic [ADDR_W-1:0] CLAIM_ADDR = 'h0100,
  parameter int                GUARD      = 2,
  parameter int                TIMEOUT    = 64
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 en_i,
  input  logic                 irq_i,
  iob_plic_claim_master_if.master iob,
  output logic                 irq_valid_o,
  output logic [ID_W-1:0]      irq_id_o,
  input  logic                 irq_ready_i,
  input  logic                 irq_done_i,
  output logic                 spurious_o,
  output logic                 err_o,
  output logic [15:0]          claim_cnt_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
    DISPATCH = 3'd3,
    SERVICE  = 3'd4,
    WR_REQ   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      guard_q, guard_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            spurious_q, spurious_d;
  logic            req_avalid;
  logic            req_write;
  logic [ID_W-1:0] rd_id;

  // Only the low ID_W bits of the claim register carry the interrupt ID.
  assign rd_id = iob.rdata[ID_W-1:0];

  logic unused_rdata;
  assign unused_rdata = ^iob.rdata;

`ifdef IOB_PLIC_CLAIM_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Next-state, datapath updates and request outputs, all decoded from state_q.
  always_comb begin
    state_d    = state_q;
    guard_d    = (guard_q != 4'd0) ? guard_q - 4'd1 : guard_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    spurious_d = 1'b0;
    req_avalid = 1'b0;
    req_write  = 1'b0;
`ifdef IOB_PLIC_CLAIM_MASTER_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en_i && irq_i && (guard_q == 4'd0)) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        req_avalid = 1'b1;
        if (iob.ready) begin
          state_d = RD_WAIT;
`ifdef IOB_PLIC_CLAIM_MASTER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      RD_WAIT: begin
        if (iob.rvalid) begin
          if (rd_id == '0) begin
            // Claim returned nothing: another target took it first.
            spurious_d = 1'b1;
            state_d    = IDLE;
            guard_d    = 4'(GUARD);
          end else begin
            id_d    = rd_id;
            cnt_d   = cnt_q + 16'd1;
            state_d = DISPATCH;
          end
        end
`ifdef IOB_PLIC_CLAIM_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
          guard_d = 4'(GUARD);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      DISPATCH: begin
        if (irq_ready_i) begin
          // A done pulse coincident with acceptance skips SERVICE entirely.
          state_d = irq_done_i ? WR_REQ : SERVICE;
        end
      end
      SERVICE: begin
        if (irq_done_i) begin
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        req_avalid = 1'b1;
        req_write  = 1'b1;
        if (iob.ready) begin
          state_d = IDLE;
          guard_d = 4'(GUARD);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      guard_q    <= 4'd0;
      id_q       <= '0;
      cnt_q      <= 16'd0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      spurious_q <= spurious_d;
    end
  end

`ifdef IOB_PLIC_CLAIM_MASTER_TIMEOUT_EN
  // Read-timeout counter and its error pulse.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Address and data are gated by avalid so every output is 0 while idle.
  assign iob.avalid  = req_avalid;
  assign iob.addr    = req_avalid ? CLAIM_ADDR : '0;
  assign iob.wstrb   = req_write ? {(DATA_W/8){1'b1}} : '0;
  assign iob.wdata   = req_write ? DATA_W'(id_q) : '0;

  assign irq_valid_o = (state_q == DISPATCH);
  assign irq_id_o    = id_q;
  assign spurious_o  = spurious_q;
  assign claim_cnt_o = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_iob_plic_claim_master.sv
// Bench for iob_plic_claim_master: a PLIC responder model and a handler model
// drive the DUT; each planned claim pushes its expected event sequence
// (read, then dispatch+write or spurious) into exp_q, and a monitor pops and
// compares whenever the DUT shows a transfer or pulse.
module tb_iob_plic_claim_master;
  localparam int          ADDR_W     = 16;
  localparam int          DATA_W     = 32;
  localparam int          ID_W       = 8;
  localparam logic [15:0] CLAIM_ADDR = 16'h0100;
  localparam int          GUARD      = 2;
  localparam int          TIMEOUT    = 64;
  localparam int          EW         = 3 + DATA_W;
  localparam logic [2:0]  EV_RD = 3'd0, EV_DISP = 3'd1, EV_WR = 3'd2, EV_SPUR = 3'd3, EV_ERR = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            en = 1'b0, irq = 1'b0, irq_ready = 1'b0, irq_done = 1'b0;
  logic            irq_valid, spurious, err;
  logic [ID_W-1:0] irq_id;
  logic [15:0]     claim_cnt;
  logic [2:0]      state;

  iob_plic_claim_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iob_plic_claim_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .CLAIM_ADDR(CLAIM_ADDR),
    .GUARD(GUARD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .arst_i(arst), .en_i(en), .irq_i(irq), .iob(bus),
    .irq_valid_o(irq_valid), .irq_id_o(irq_id), .irq_ready_i(irq_ready),
    .irq_done_i(irq_done), .spurious_o(spurious), .err_o(err),
    .claim_cnt_o(claim_cnt), .state_o(state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] plic_q[$];
  logic [15:0]       cnt_model = 16'd0;
  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic sb(input string name, input logic [EW-1:0] got);
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got unexpected event %0h, expected none (cycle %0d)", name, got, cyc);
    end else begin
      check(name, 64'(got), 64'(exp_q.pop_front()));
    end
  endtask

  // Reference behaviour of one claim: the PLIC returns rdata; a zero ID is
  // spurious, anything else is dispatched and then completed with that ID.
  task automatic push_claim(input logic [DATA_W-1:0] rdata);
    logic [ID_W-1:0] id;
    id = rdata[ID_W-1:0];
    plic_q.push_back(rdata);
    exp_q.push_back({EV_RD, 32'(CLAIM_ADDR)});
    if (id == '0) begin
      exp_q.push_back({EV_SPUR, 32'd0});
    end else begin
      exp_q.push_back({EV_DISP, 32'(id)});
      exp_q.push_back({EV_WR, 32'(id)});
      cnt_model = cnt_model + 16'd1;
    end
  endtask

  // ---------------- driver: PLIC responder + handler ----------------
  int ready_pct = 100, stall_n = 0, rv_min = 1, rv_max = 1;
  int hr_pct = 100, done_min = 0, done_max = 0, stray_pct = 0;
  bit drop_rv = 1'b0, force_rv = 1'b0;
  int rv_cnt = 0, av_run = 0, h_cnt = 0;
  bit h_busy = 1'b0;
  logic [DATA_W-1:0] rv_data = '0;

  initial begin : driver
    int d;
    bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (arst) begin
        bus.ready = 1'b0; bus.rvalid = 1'b0; irq_ready = 1'b0; irq_done = 1'b0; irq = 1'b0;
        rv_cnt = 0; av_run = 0; h_busy = 1'b0;
        continue;
      end
      // read data channel
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      if (force_rv) begin
        bus.rvalid = 1'b1; bus.rdata = 32'h11; force_rv = 1'b0;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin bus.rvalid = 1'b1; bus.rdata = rv_data; end
      end else if ($urandom_range(99) < stray_pct) begin
        bus.rvalid = 1'b1;
      end
      // request channel
      if (bus.avalid) begin
        av_run++;
        bus.ready = (av_run > stall_n) && ($urandom_range(99) < ready_pct);
      end else begin
        av_run = 0;
        bus.ready = ($urandom_range(1) == 1);
      end
      if (bus.avalid && bus.ready && bus.wstrb == '0) begin
        rv_data = (plic_q.size() > 0) ? plic_q.pop_front() : '0;
        rv_cnt  = drop_rv ? 0 : $urandom_range(rv_max, rv_min);
      end
      irq = (plic_q.size() > 0);
      // handler
      irq_done = 1'b0;
      if (h_busy) begin
        irq_ready = ($urandom_range(1) == 1);
        h_cnt--;
        if (h_cnt == 0) begin irq_done = 1'b1; h_busy = 1'b0; end
      end else begin
        irq_ready = ($urandom_range(99) < hr_pct);
        if (irq_valid && irq_ready) begin
          d = $urandom_range(done_max, done_min);
          if (d == 0) irq_done = 1'b1;
          else begin h_busy = 1'b1; h_cnt = d; end
        end else if ($urandom_range(99) < stray_pct) begin
          irq_done = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int  av_cycles = 0, wr_acc_n = 0, err_n = 0, earliest_rd = -1;
  int  irq_rise = 0, rd_av_rise = 0, wr_av_rise = 0, iv_rise = 0;
  int  rv_cyc = 0, done_cyc = 0, rd_acc_cyc = 0, err_cyc = 0;
  bit  prev_av = 0, prev_acc = 0, prev_iv = 0, prev_iacc = 0, prev_irq = 0;
  logic [63:0]     held_req = '0;
  logic [ID_W-1:0] held_id  = '0;

  initial begin : monitor
    logic [63:0] cur;
    forever begin
      @(negedge clk); #2;
      if (arst) begin
        prev_av = 0; prev_acc = 0; prev_iv = 0; prev_iacc = 0; prev_irq = 0; earliest_rd = -1;
        continue;
      end
      if (irq && !prev_irq) irq_rise = cyc;
      prev_irq = irq;
      if (bus.rvalid) rv_cyc = cyc;
      if (irq_done) done_cyc = cyc;
      if (bus.avalid) begin
        av_cycles++;
        cur = {12'd0, bus.addr, bus.wdata, bus.wstrb};
        if (prev_av && !prev_acc) begin
          check("req_hold", cur, held_req);
        end else if (bus.wstrb == '0) begin
          rd_av_rise = cyc;
          if (earliest_rd >= 0) check("guard_gap", 64'(cyc >= earliest_rd), 64'd1);
        end else begin
          wr_av_rise = cyc;
        end
        held_req = cur;
        prev_acc = bus.ready;
        if (bus.ready) begin
          if (bus.wstrb == '0) begin
            sb("read", {EV_RD, 32'(bus.addr)});
            rd_acc_cyc = cyc;
          end else if (bus.wstrb == '1) begin
            check("wr_addr", 64'(bus.addr), 64'(CLAIM_ADDR));
            sb("write", {EV_WR, bus.wdata});
            wr_acc_n++;
            earliest_rd = cyc + GUARD + 2;
          end else begin
            check("wstrb", 64'(bus.wstrb), 64'hF);
          end
        end
      end
      prev_av = bus.avalid;
      if (irq_valid) begin
        if (prev_iv && !prev_iacc) check("id_hold", 64'(irq_id), 64'(held_id));
        else iv_rise = cyc;
        held_id   = irq_id;
        prev_iacc = irq_ready;
        if (irq_ready) sb("dispatch", {EV_DISP, 32'(irq_id)});
      end
      prev_iv = irq_valid;
      if (spurious) begin
        sb("spurious", {EV_SPUR, 32'd0});
        earliest_rd = cyc + GUARD + 1;
      end
      if (err) begin
        sb("err", {EV_ERR, 32'd0});
        err_cyc = cyc; err_n++;
        earliest_rd = cyc + GUARD + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic drain(input string name);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || h_busy) && b < 3000) begin
      @(negedge clk); b++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bus"},   {11'd0, bus.avalid, bus.addr, bus.wdata, bus.wstrb}, 64'd0);
    check({tag, "_irq"},   64'({irq_valid, irq_id}), 64'd0);
    check({tag, "_pulse"}, 64'({spurious, err}), 64'd0);
    check({tag, "_cnt"},   64'(claim_cnt), 64'd0);
    check({tag, "_state"}, 64'(state), 64'd0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int base, b;
    repeat (3) @(negedge clk);
    check_reset("reset");
    arst = 1'b0;
    en   = 1'b1;
    repeat (2) @(negedge clk);

    // Basic claim: ready tied high, rvalid one cycle after acceptance.
    done_min = 2; done_max = 2;
    push_claim(32'd5);
    drain("basic");
    check("lat_irq_to_rd", 64'(rd_av_rise - irq_rise), 64'd1);
    check("lat_rv_to_disp", 64'(iv_rise - rv_cyc), 64'd1);
    check("lat_done_to_wr", 64'(wr_av_rise - done_cyc), 64'd1);
    check("cnt_basic", 64'(claim_cnt), 64'(cnt_model));

    // Spurious claim followed by a real one; guard spacing checked by monitor.
    done_min = 0; done_max = 0;
    push_claim(32'd0);
    push_claim(32'd7);
    drain("spurious");
    check("cnt_spurious", 64'(claim_cnt), 64'(cnt_model));

    // Back-pressure: ready held low for 3 cycles on each request.
    stall_n = 3;
    push_claim(32'hABCD_0042);
    drain("stall");
    stall_n = 0;
    check("cnt_stall", 64'(claim_cnt), 64'(cnt_model));

    // Disabled: no bus activity while irq is pending.
    en = 1'b0;
    push_claim(32'd9);
    base = av_cycles;
    repeat (20) @(negedge clk);
    check("en_off_idle", 64'(av_cycles - base), 64'd0);
    // Enabled, then dropped during SERVICE: the complete write still happens.
    done_min = 8; done_max = 8;
    en = 1'b1;
    b = 0;
    while (!h_busy && b < 200) begin @(negedge clk); b++; end
    check("svc_reached", 64'(h_busy), 64'd1);
    en = 1'b0;
    base = wr_acc_n;
    drain("en_drop");
    check("en_drop_write", 64'(wr_acc_n - base), 64'd1);
    check("cnt_en", 64'(claim_cnt), 64'(cnt_model));
    en = 1'b1;
    done_min = 0; done_max = 3;

    // Reset while the ID is offered to the handler.
    hr_pct = 0;
    push_claim(32'd3);
    b = 0;
    while (!irq_valid && b < 200) begin @(negedge clk); b++; end
    arst = 1'b1;
    exp_q.delete();
    plic_q.delete();
    cnt_model = 16'd0;
    @(posedge clk); #1;
    check_reset("mid_reset");
    @(negedge clk);
    arst   = 1'b0;
    hr_pct = 100;
    repeat (4) @(negedge clk);

`ifdef IOB_PLIC_CLAIM_MASTER_TIMEOUT_EN
    // Read data never returns: err after TIMEOUT cycles, late data ignored.
    drop_rv = 1'b1;
    plic_q.push_back(32'd21);
    exp_q.push_back({EV_RD, 32'(CLAIM_ADDR)});
    exp_q.push_back({EV_ERR, 32'd0});
    base = err_n;
    b = 0;
    while (err_n == base && b < 400) begin @(negedge clk); b++; end
    check("tmo_seen", 64'(err_n - base), 64'd1);
    check("tmo_latency", 64'(err_cyc - rd_acc_cyc), 64'(TIMEOUT + 1));
    drop_rv  = 1'b0;
    force_rv = 1'b1;
    drain("tmo");
    check("cnt_tmo", 64'(claim_cnt), 64'(cnt_model));
`endif

    // Randomized traffic with back-pressure, stray strobes and en toggling.
    ready_pct = 60; rv_min = 1; rv_max = 4; hr_pct = 60; done_min = 0; done_max = 3; stray_pct = 10;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(4) == 0) push_claim({$urandom_range(255, 0) << 8});
      else push_claim({24'($urandom), 8'($urandom_range(255, 1))});
      en = ($urandom_range(9) != 0);
      repeat ($urandom_range(12, 0)) @(negedge clk);
    end
    en = 1'b1;
    drain("random");
    check("cnt_random", 64'(claim_cnt), 64'(cnt_model));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
